usb_pkt_decoder: RTL and testbench
==================================

USB_PKT_DECODER -- requirements
Module: usb_pkt_decoder

Interface
REQ-001 Parameter NUM_EP, default 4, number of decoded endpoints (1..16).
REQ-002 Parameter MAX_PKT, default 64, maximum DATA payload bytes, excluding PID and CRC16 (1..1023).
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk  in  1  system clock (24 MHz); single clock domain.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from SIE.
- rx_active  in  1  high between SYNC and EOP.
- rx_valid  in  1  one-cycle byte-valid pulse.
- rx_error  in  1  SIE error.
- dev_address  in  7  assigned device address.
- pid  out  4  last valid PID (types::pid_t).
- pid_valid  out  1  one-cycle pulse per valid PID byte.
- address  out  7  token address.
- end_point  out  4  token endpoint.
- ep_sel  out  NUM_EP  one-hot copy of end_point.
- token_valid  out  1  one-cycle pulse: token CRC5 good, address matches, endpoint < NUM_EP.
- data_o  out  8  payload byte.
- data_valid  out  1  one-cycle pulse per payload byte.
- data_done  out  1  one-cycle pulse at end of DATA packet.
- crc16_ok  out  1  CRC16 result; valid with data_done.
- pkt_error  out  1  one-cycle pulse on any packet error.
- hs_valid  out  1  one-cycle pulse after an ACK, NAK or STALL packet ends cleanly.
- frame  out  11  SOF frame number.
- sof_valid  out  1  one-cycle pulse when SOF CRC5 is good.

Function
REQ-004 PID byte valid iff rx_data[3:0] == ~rx_data[7:4]; an invalid PID raises pkt_error and enters DROP.
REQ-005 States: IDLE, TOKEN0, TOKEN1, DATA, HS, DROP.
REQ-006 IDLE: first rx_valid byte with rx_active high is the PID. OUT, IN, SETUP, SOF -> TOKEN0; DATA0, DATA1 -> DATA; ACK, NAK, STALL -> HS; other valid PIDs -> DROP.
REQ-007 TOKEN0 latches byte 1; TOKEN1 checks CRC5 over the 16 token bits.
- CRC5: LSB first, init 5'h1F, reflected polynomial 5'b10100, reflected residual 5'b00110.
- Checks complete one cycle after byte 2; the state then returns to DROP until rx_active falls.
REQ-008 A token with bad CRC5, a foreign address, or endpoint >= NUM_EP pulses no token_valid and no pkt_error for address or endpoint mismatches; a bad CRC5 pulses pkt_error.
REQ-009 A good SOF updates frame = {byte2[2:0], byte1} and pulses sof_valid; pid_valid is still pulsed.
REQ-010 DATA uses a 2-byte delay line, so the two CRC16 bytes are never emitted. byte n is emitted on data_valid when byte n+2 arrives.
REQ-011 CRC16 is computed over all bytes after the PID: LSB first, init 16'hFFFF, reflected polynomial 16'hA001, good residual 16'hB001.
REQ-012 When rx_active falls in DATA:
- data_done pulses the next cycle.
- crc16_ok = residual match and byte count >= 2.
- If crc16_ok is 0, pkt_error pulses in the same cycle.
REQ-013 If payload exceeds MAX_PKT bytes: pkt_error pulses, the state goes to DROP, and no data_done is issued.
REQ-014 HS: a further byte before rx_active falls gives pkt_error; otherwise hs_valid pulses on the fall.
REQ-015 rx_error in any non-IDLE state: pkt_error pulses and the state goes to DROP. DROP returns to IDLE when rx_active is low.
REQ-016 rx_active falling in TOKEN0 or TOKEN1 gives pkt_error and a return to IDLE.
REQ-017 rx_active low in IDLE: no outputs pulse.

Reset
REQ-018 On reset: state IDLE, pid RESERVED, and all other outputs 0.
REQ-019 Reset mid-packet discards the packet with no pulses; remaining bytes are ignored until the next rx_active rise.

Configuration
REQ-020 Macro USB_SOF_DECODE_EN enables SOF decoding.
- Defined: SOF is decoded per REQ-009.
- Undefined: frame is tied to 0, sof_valid is tied to 0, and SOF packets go to DROP after the pid_valid pulse.

Verification
REQ-021 SETUP token 2D 00 10, dev_address 0 -> pid_valid (pid SETUP), token_valid, address 0, end_point 0, ep_sel 4'b0001.
REQ-022 OUT token 0x E1 00 10 with dev_address 5 -> pid_valid only; no token_valid, no pkt_error.
REQ-023 DATA0 packet C3 80 06 00 01 00 00 40 00 DD 94 -> data_valid for exactly 8 bytes 80..00, then data_done with crc16_ok 1.
REQ-024 Same DATA0 packet with last byte 95 -> 8 data_valid pulses, then data_done with crc16_ok 0 and pkt_error.
REQ-025 ACK D2 then EOP -> pid_valid, then hs_valid.
REQ-026 DATA1 packet with MAX_PKT+1 payload bytes -> pkt_error at byte MAX_PKT+1 and no data_done.

Source files
------------

// File: rtl/usb_pkt_decoder.sv
// USB packet decoder: PID check, token/SOF CRC5, DATA CRC16 with 2-byte CRC strip, handshake detect.
// Outputs registered (1 cycle after the sampled byte/EOP); no backpressure. SOF decode enabled by USB_SOF_DECODE_EN.
module usb_pkt_decoder #(
  parameter int NUM_EP  = 4,
  parameter int MAX_PKT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_active,
  input  logic              rx_valid,
  input  logic              rx_error,
  input  logic [6:0]        dev_address,
  output logic [3:0]        pid,
  output logic              pid_valid,
  output logic [6:0]        address,
  output logic [3:0]        end_point,
  output logic [NUM_EP-1:0] ep_sel,
  output logic              token_valid,
  output logic [7:0]        data_o,
  output logic              data_valid,
  output logic              data_done,
  output logic              crc16_ok,
  output logic              pkt_error,
  output logic              hs_valid,
  output logic [10:0]       frame,
  output logic              sof_valid
);

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  typedef enum logic [2:0] {
    S_IDLE, S_TOKEN0, S_TOKEN1, S_DATA, S_HS, S_DROP
  } state_t;

  state_t            r_state;
  logic              r_armed;
  logic [7:0]        r_byte1;
  logic [4:0]        r_crc5;
  logic [15:0]       r_crc16;
  logic [10:0]       r_cnt;
  logic [7:0]        r_dly0;
  logic [7:0]        r_dly1;

  logic              w_pid_ok;
  logic [4:0]        w_crc5_nxt;
  logic [15:0]       w_crc16_nxt;
  logic [6:0]        w_tok_addr;
  logic [3:0]        w_tok_ep;
  logic              w_crc5_good;
  logic              w_ep_in_range;
  logic              w_data_good;
  logic [NUM_EP-1:0] w_ep_sel;

  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 5'b10100;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_comb begin
    w_pid_ok      = (rx_data[3:0] == ~rx_data[7:4]);
    w_crc5_nxt    = crc5_byte(r_crc5, rx_data);
    w_crc16_nxt   = crc16_byte(r_crc16, rx_data);
    w_tok_addr    = r_byte1[6:0];
    w_tok_ep      = {rx_data[2:0], r_byte1[7]};
    w_crc5_good   = (w_crc5_nxt == 5'b00110);
    w_ep_in_range = ({1'b0, w_tok_ep} < 5'(NUM_EP));
    w_data_good   = (r_crc16 == 16'hB001) && (r_cnt >= 11'd2);
    w_ep_sel      = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (w_tok_ep == 4'(i)) w_ep_sel[i] = 1'b1;
    end
  end

`ifdef USB_SOF_DECODE_EN
  logic [10:0] r_frame;
  logic        r_sof_valid;
  assign frame     = r_frame;
  assign sof_valid = r_sof_valid;
`else
  assign frame     = 11'd0;
  assign sof_valid = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_armed     <= 1'b0;
      r_byte1     <= 8'd0;
      r_crc5      <= 5'h1F;
      r_crc16     <= 16'hFFFF;
      r_cnt       <= 11'd0;
      r_dly0      <= 8'd0;
      r_dly1      <= 8'd0;
      pid         <= 4'h0;
      pid_valid   <= 1'b0;
      address     <= 7'd0;
      end_point   <= 4'd0;
      ep_sel      <= '0;
      token_valid <= 1'b0;
      data_o      <= 8'd0;
      data_valid  <= 1'b0;
      data_done   <= 1'b0;
      crc16_ok    <= 1'b0;
      pkt_error   <= 1'b0;
      hs_valid    <= 1'b0;
`ifdef USB_SOF_DECODE_EN
      r_frame     <= 11'd0;
      r_sof_valid <= 1'b0;
`endif
    end else begin
      pid_valid   <= 1'b0;
      token_valid <= 1'b0;
      data_valid  <= 1'b0;
      data_done   <= 1'b0;
      pkt_error   <= 1'b0;
      hs_valid    <= 1'b0;
`ifdef USB_SOF_DECODE_EN
      r_sof_valid <= 1'b0;
`endif
      // A packet already in flight at reset release is skipped until rx_active drops.
      if (!rx_active) r_armed <= 1'b1;

      if (r_state != S_IDLE && rx_error) begin
        pkt_error <= 1'b1;
        r_state   <= S_DROP;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (rx_active && rx_valid && r_armed) begin
              if (!w_pid_ok) begin
                pkt_error <= 1'b1;
                r_state   <= S_DROP;
              end else begin
                pid       <= rx_data[3:0];
                pid_valid <= 1'b1;
                r_crc5    <= 5'h1F;
                r_crc16   <= 16'hFFFF;
                r_cnt     <= 11'd0;
                case (rx_data[3:0])
                  PID_OUT, PID_IN, PID_SETUP: r_state <= S_TOKEN0;
                  PID_SOF: begin
`ifdef USB_SOF_DECODE_EN
                    r_state <= S_TOKEN0;
`else
                    r_state <= S_DROP;
`endif
                  end
                  PID_DATA0, PID_DATA1:        r_state <= S_DATA;
                  PID_ACK, PID_NAK, PID_STALL: r_state <= S_HS;
                  default:                     r_state <= S_DROP;
                endcase
              end
            end
          end
          S_TOKEN0: begin
            if (!rx_active) begin
              pkt_error <= 1'b1;
              r_state   <= S_IDLE;
            end else if (rx_valid) begin
              r_byte1 <= rx_data;
              r_crc5  <= w_crc5_nxt;
              r_state <= S_TOKEN1;
            end
          end
          S_TOKEN1: begin
            if (!rx_active) begin
              pkt_error <= 1'b1;
              r_state   <= S_IDLE;
            end else if (rx_valid) begin
              r_state <= S_DROP;
              if (!w_crc5_good) begin
                pkt_error <= 1'b1;
              end else begin
`ifdef USB_SOF_DECODE_EN
                if (pid == PID_SOF) begin
                  r_frame     <= {rx_data[2:0], r_byte1};
                  r_sof_valid <= 1'b1;
                end else
`endif
                if (w_tok_addr == dev_address && w_ep_in_range) begin
                  token_valid <= 1'b1;
                  address     <= w_tok_addr;
                  end_point   <= w_tok_ep;
                  ep_sel      <= w_ep_sel;
                end
              end
            end
          end
          S_DATA: begin
            if (!rx_active) begin
              data_done <= 1'b1;
              crc16_ok  <= w_data_good;
              pkt_error <= !w_data_good;
              r_state   <= S_IDLE;
            end else if (rx_valid) begin
              // r_cnt counts bytes after the PID; the last two are CRC and never emitted.
              if (r_cnt == 11'(MAX_PKT + 2)) begin
                pkt_error <= 1'b1;
                r_state   <= S_DROP;
              end else begin
                r_crc16 <= w_crc16_nxt;
                r_dly0  <= rx_data;
                r_dly1  <= r_dly0;
                r_cnt   <= r_cnt + 11'd1;
                if (r_cnt >= 11'd2) begin
                  data_o     <= r_dly1;
                  data_valid <= 1'b1;
                end
              end
            end
          end
          S_HS: begin
            if (!rx_active) begin
              hs_valid <= 1'b1;
              r_state  <= S_IDLE;
            end else if (rx_valid) begin
              pkt_error <= 1'b1;
              r_state   <= S_DROP;
            end
          end
          S_DROP: begin
            if (!rx_active) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_pkt_decoder.sv
// Directed bench for usb_pkt_decoder: packet table plus multi-cycle corner sequences.
module tb_usb_pkt_decoder;

`ifdef USB_SOF_DECODE_EN
  localparam int SOF_EN = 1;
`else
  localparam int SOF_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_active;
  logic        rx_valid;
  logic        rx_error;
  logic [6:0]  dev_address;
  logic [3:0]  pid;
  logic        pid_valid;
  logic [6:0]  address;
  logic [3:0]  end_point;
  logic [3:0]  ep_sel;
  logic        token_valid;
  logic [7:0]  data_o;
  logic        data_valid;
  logic        data_done;
  logic        crc16_ok;
  logic        pkt_error;
  logic        hs_valid;
  logic [10:0] frame;
  logic        sof_valid;

  usb_pkt_decoder #(.NUM_EP(4), .MAX_PKT(64)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_active(rx_active),
    .rx_valid(rx_valid), .rx_error(rx_error), .dev_address(dev_address),
    .pid(pid), .pid_valid(pid_valid), .address(address), .end_point(end_point),
    .ep_sel(ep_sel), .token_valid(token_valid), .data_o(data_o),
    .data_valid(data_valid), .data_done(data_done), .crc16_ok(crc16_ok),
    .pkt_error(pkt_error), .hs_valid(hs_valid), .frame(frame), .sof_valid(sof_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Running pulse totals; each test takes the difference across its packet.
  int t_pidv = 0, t_tok = 0, t_err = 0, t_hs = 0, t_dv = 0, t_done = 0, t_sof = 0;
  logic [7:0] cap [0:255];
  logic       last_ok = 1'b0;

  always @(negedge clk) begin
    if (pid_valid)   t_pidv++;
    if (token_valid) t_tok++;
    if (pkt_error)   t_err++;
    if (hs_valid)    t_hs++;
    if (sof_valid)   t_sof++;
    if (data_done) begin
      t_done++;
      last_ok = crc16_ok;
    end
    if (data_valid) begin
      cap[t_dv % 256] = data_o;
      t_dv++;
    end
  end

  typedef struct {
    logic [95:0] b;
    int          len;
    logic [6:0]  dev;
    int          pidv;
    logic [3:0]  pid;
    int          tok;
    logic [6:0]  addr;
    logic [3:0]  ep;
    logic [3:0]  sel;
    int          err;
    int          hs;
    int          dv;
    int          done;
    logic        ok;
    int          sof;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [0:NV-1];

  int s_pidv, s_tok, s_err, s_hs, s_dv, s_done, s_sof;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] vb(input logic [95:0] b, input int len, input int i);
    logic [95:0] t;
    t = b >> (8 * (len - 1 - i));
    return t[7:0];
  endfunction

  task automatic put_byte(input logic [7:0] d);
    @(posedge clk); #1;
    rx_data  = d;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic snap();
    s_pidv = t_pidv; s_tok = t_tok; s_err = t_err; s_hs = t_hs;
    s_dv = t_dv; s_done = t_done; s_sof = t_sof;
  endtask

  task automatic finish_pkt();
    @(posedge clk); #1;
    rx_active = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [95:0] b, input int len);
    @(posedge clk); #1;
    rx_active = 1'b1;
    for (int i = 0; i < len; i++) put_byte(vb(b, len, i));
    finish_pkt();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1);
  end

  initial begin
    //            bytes (right-aligned)               len dev  pidv pid  tok addr ep  sel   err hs dv done ok sof
    vt[0]  = '{96'h2D0010,                            3, 7'd0, 1, 4'hD, 1, 7'd0, 4'd0, 4'b0001, 0, 0, 0, 0, 1'b0, 0};
    vt[1]  = '{96'hE10010,                            3, 7'd5, 1, 4'h1, 0, 7'd0, 4'd0, 4'b0000, 0, 0, 0, 0, 1'b0, 0};
    vt[2]  = '{96'hC3_80_06_00_01_00_00_40_00_DD_94, 11, 7'd0, 1, 4'h3, 0, 7'd0, 4'd0, 4'b0000, 0, 0, 8, 1, 1'b1, 0};
    vt[3]  = '{96'hC3_80_06_00_01_00_00_40_00_DD_95, 11, 7'd0, 1, 4'h3, 0, 7'd0, 4'd0, 4'b0000, 1, 0, 8, 1, 1'b0, 0};
    vt[4]  = '{96'hD2,                                1, 7'd0, 1, 4'h2, 0, 7'd0, 4'd0, 4'b0000, 0, 1, 0, 0, 1'b0, 0};
    vt[5]  = '{96'h2E,                                1, 7'd0, 0, 4'h2, 0, 7'd0, 4'd0, 4'b0000, 1, 0, 0, 0, 1'b0, 0};
    vt[6]  = '{96'h2D0018,                            3, 7'd0, 1, 4'hD, 0, 7'd0, 4'd0, 4'b0000, 1, 0, 0, 0, 1'b0, 0};
    vt[7]  = '{96'h5A00,                              2, 7'd0, 1, 4'hA, 0, 7'd0, 4'd0, 4'b0000, 1, 0, 0, 0, 1'b0, 0};
    vt[8]  = '{96'h4B0000,                            3, 7'd0, 1, 4'hB, 0, 7'd0, 4'd0, 4'b0000, 0, 0, 0, 1, 1'b1, 0};
    vt[9]  = '{96'hC300,                              2, 7'd0, 1, 4'h3, 0, 7'd0, 4'd0, 4'b0000, 1, 0, 0, 1, 1'b0, 0};
    vt[10] = '{96'hA50010,                            3, 7'd0, 1, 4'h5, 0, 7'd0, 4'd0, 4'b0000, 0, 0, 0, 0, 1'b0, SOF_EN};
    vt[11] = '{96'h698560,                            3, 7'd5, 1, 4'h9, 1, 7'd5, 4'd1, 4'b0010, 0, 0, 0, 0, 1'b0, 0};
    vt[12] = '{96'hE10042,                            3, 7'd0, 1, 4'h1, 0, 7'd0, 4'd0, 4'b0000, 0, 0, 0, 0, 1'b0, 0};
    vt[13] = '{96'h2D00,                              2, 7'd0, 1, 4'hD, 0, 7'd0, 4'd0, 4'b0000, 1, 0, 0, 0, 1'b0, 0};
    vt[14] = '{96'h2D,                                1, 7'd0, 1, 4'hD, 0, 7'd0, 4'd0, 4'b0000, 1, 0, 0, 0, 1'b0, 0};
    vt[15] = '{96'h1E,                                1, 7'd0, 1, 4'hE, 0, 7'd0, 4'd0, 4'b0000, 0, 1, 0, 0, 1'b0, 0};
    vt[16] = '{96'hB4,                                1, 7'd0, 1, 4'h4, 0, 7'd0, 4'd0, 4'b0000, 0, 0, 0, 0, 1'b0, 0};

    reset = 1'b1; rx_data = 8'h00; rx_active = 1'b0; rx_valid = 1'b0;
    rx_error = 1'b0; dev_address = 7'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset pid",         int'(pid), 0);
    chk("reset pid_valid",   int'(pid_valid), 0);
    chk("reset token_valid", int'(token_valid), 0);
    chk("reset address",     int'(address), 0);
    chk("reset ep_sel",      int'(ep_sel), 0);
    chk("reset data_valid",  int'(data_valid), 0);
    chk("reset crc16_ok",    int'(crc16_ok), 0);
    chk("reset pkt_error",   int'(pkt_error), 0);
    chk("reset frame",       int'(frame), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < NV; v++) begin
      dev_address = vt[v].dev;
      snap();
      send(vt[v].b, vt[v].len);
      chk($sformatf("v%0d pid_valid", v),   t_pidv - s_pidv, vt[v].pidv);
      chk($sformatf("v%0d pid", v),         int'(pid), int'(vt[v].pid));
      chk($sformatf("v%0d token_valid", v), t_tok - s_tok,   vt[v].tok);
      chk($sformatf("v%0d pkt_error", v),   t_err - s_err,   vt[v].err);
      chk($sformatf("v%0d hs_valid", v),    t_hs - s_hs,     vt[v].hs);
      chk($sformatf("v%0d data_valid", v),  t_dv - s_dv,     vt[v].dv);
      chk($sformatf("v%0d data_done", v),   t_done - s_done, vt[v].done);
      chk($sformatf("v%0d sof_valid", v),   t_sof - s_sof,   vt[v].sof);
      if (vt[v].done == 1)
        chk($sformatf("v%0d crc16_ok", v), int'(last_ok), int'(vt[v].ok));
      if (vt[v].tok == 1) begin
        chk($sformatf("v%0d address", v),   int'(address),   int'(vt[v].addr));
        chk($sformatf("v%0d end_point", v), int'(end_point), int'(vt[v].ep));
        chk($sformatf("v%0d ep_sel", v),    int'(ep_sel),    int'(vt[v].sel));
      end
      for (int i = 0; i < vt[v].dv && i < t_dv - s_dv; i++)
        chk($sformatf("v%0d payload[%0d]", v, i), int'(cap[(s_dv + i) % 256]),
            int'(vb(vt[v].b, vt[v].len, i + 1)));
    end

    // DATA1 with MAX_PKT+1 payload bytes plus two CRC bytes.
    dev_address = 7'd0;
    snap();
    @(posedge clk); #1;
    rx_active = 1'b1;
    put_byte(8'h4B);
    for (int i = 0; i < 67; i++) put_byte(8'(i + 1));
    finish_pkt();
    chk("ovf pid_valid",  t_pidv - s_pidv, 1);
    chk("ovf data_valid", t_dv - s_dv, 64);
    chk("ovf pkt_error",  t_err - s_err, 1);
    chk("ovf data_done",  t_done - s_done, 0);
    for (int i = 0; i < 64 && i < t_dv - s_dv; i++)
      chk($sformatf("ovf payload[%0d]", i), int'(cap[(s_dv + i) % 256]), i + 1);

    // rx_error partway through a DATA packet.
    snap();
    @(posedge clk); #1;
    rx_active = 1'b1;
    put_byte(8'hC3); put_byte(8'h80); put_byte(8'h06);
    @(posedge clk); #1; rx_error = 1'b1;
    @(posedge clk); #1; rx_error = 1'b0;
    put_byte(8'h00);
    finish_pkt();
    chk("rxerr pkt_error",  t_err - s_err, 1);
    chk("rxerr data_done",  t_done - s_done, 0);
    chk("rxerr data_valid", t_dv - s_dv, 0);

    // Bytes while rx_active is low in IDLE.
    snap();
    put_byte(8'hD2); put_byte(8'h2D);
    repeat (3) @(posedge clk); #1;
    chk("idle pid_valid", t_pidv - s_pidv, 0);
    chk("idle pkt_error", t_err - s_err, 0);

    // Reset mid-packet: the tail of the packet, including a valid-looking PID, is ignored.
    snap();
    @(posedge clk); #1;
    rx_active = 1'b1;
    put_byte(8'hC3); put_byte(8'h80);
    @(posedge clk); #1; reset = 1'b1;
    repeat (2) @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("rstmid pid", int'(pid), 0);
    put_byte(8'h00); put_byte(8'hD2); put_byte(8'h01);
    finish_pkt();
    chk("rstmid pid_valid", t_pidv - s_pidv, 1);
    chk("rstmid pkt_error", t_err - s_err, 0);
    chk("rstmid hs_valid",  t_hs - s_hs, 0);
    chk("rstmid data_done", t_done - s_done, 0);
    snap();
    send(96'hD2, 1);
    chk("post-reset ack hs_valid",  t_hs - s_hs, 1);
    chk("post-reset ack pid_valid", t_pidv - s_pidv, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
